// File: rtl/snake_pixel_compositor.sv
// Two-stage pixel compositor: stage 1 resolves layer priority with blink blanking,
// stage 2 applies the frame-latched play/pause/game-over mode and registers all outputs.
module snake_pixel_compositor #(
    parameter int                       NUM_LAYERS      = 4,
    parameter int                       COLOR_W         = 4,
    parameter int                       BLINK_FRAMES    = 30,
    parameter bit                       SYNC_ACTIVE_LOW = 1,
    parameter logic [3*COLOR_W-1:0]     GAMEOVER_RGB    = {4'h0, 4'h0, 4'hf}
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             de,
    input  logic                             hsync,
    input  logic                             vsync,
    input  logic [NUM_LAYERS-1:0]            layer_draw,
    input  logic [NUM_LAYERS*3*COLOR_W-1:0]  layer_rgb,
    input  logic [3*COLOR_W-1:0]             bg_rgb,
    input  logic [NUM_LAYERS-1:0]            blink_mask,
    input  logic [1:0]                       mode,
    output logic                             vga_hsync,
    output logic                             vga_vsync,
    output logic [COLOR_W-1:0]               vga_r,
    output logic [COLOR_W-1:0]               vga_g,
    output logic [COLOR_W-1:0]               vga_b,
    output logic                             frame_start
);

    localparam int         PIX_W      = 3 * COLOR_W;
    localparam logic       SYNC_IDLE  = SYNC_ACTIVE_LOW;
    localparam logic       SYNC_ON    = !SYNC_ACTIVE_LOW;
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        MODE_PLAY  = 2'd0,
        MODE_PAUSE = 2'd1,
        MODE_OVER  = 2'd2
    } mode_t;

    mode_t              active_mode;
    mode_t              next_mode;
    logic [7:0]         frame_cnt;
    logic               blink_phase;
    logic               frame_edge;

    logic               s1_de;
    logic               s1_hs;
    logic               s1_vs;
    logic [PIX_W-1:0]   s1_rgb;

    logic [NUM_LAYERS-1:0] eff_draw;
    logic [PIX_W-1:0]      sel_rgb;
    logic                  found;
    logic [PIX_W-1:0]      out_rgb;

    // Blinking layers drop out of the priority search entirely.
    always_comb begin
        eff_draw = layer_draw & ~({NUM_LAYERS{blink_phase}} & blink_mask);
        sel_rgb  = bg_rgb;
        found    = 1'b0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (eff_draw[i] && !found) begin
                sel_rgb = layer_rgb[i*PIX_W +: PIX_W];
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_de  <= 1'b0;
            s1_hs  <= SYNC_IDLE;
            s1_vs  <= SYNC_IDLE;
            s1_rgb <= '0;
        end else begin
            s1_de  <= de;
            s1_hs  <= hsync;
            s1_vs  <= vsync;
            s1_rgb <= sel_rgb;
        end
    end

    // vga_vsync is s1_vs one cycle later, so it doubles as the edge-detect history.
    assign frame_edge = (s1_vs == SYNC_ON) && (vga_vsync != SYNC_ON);

    always_comb begin
        case (mode)
            2'd1:    next_mode = MODE_PAUSE;
            2'd2:    next_mode = MODE_OVER;
            default: next_mode = MODE_PLAY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_mode <= MODE_PLAY;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_edge) begin
            active_mode <= next_mode;
            if (next_mode == MODE_OVER) begin
                frame_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (next_mode == MODE_PLAY) begin
                if (frame_cnt >= BLINK_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        out_rgb = '0;
        if (s1_de) begin
            case (active_mode)
                MODE_PAUSE: begin
                    for (int unsigned c = 0; c < 3; c++) begin
                        out_rgb[c*COLOR_W +: COLOR_W] = s1_rgb[c*COLOR_W +: COLOR_W] >> 1;
                    end
                end
                MODE_OVER: out_rgb = GAMEOVER_RGB;
                default:   out_rgb = s1_rgb;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_hsync   <= SYNC_IDLE;
            vga_vsync   <= SYNC_IDLE;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            frame_start <= 1'b0;
        end else begin
            vga_hsync             <= s1_hs;
            vga_vsync             <= s1_vs;
            {vga_r, vga_g, vga_b} <= out_rgb;
            frame_start           <= frame_edge;
        end
    end

endmodule

// File: tb/tb_snake_pixel_compositor.sv
// Scoreboard bench for snake_pixel_compositor: an independent mode/blink model
// predicts each output pixel, which is compared two clocks after it is driven.
module tb_snake_pixel_compositor;

    localparam int NL = 4;
    localparam int CW = 4;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          de = 1'b0;
    logic          hsync = 1'b1;
    logic          vsync = 1'b1;
    logic [NL-1:0] layer_draw = '0;
    logic [47:0]   layer_rgb = '0;
    logic [11:0]   bg_rgb = 12'h222;
    logic [NL-1:0] blink_mask = '0;
    logic [1:0]    mode = 2'd0;
    logic          vga_hsync, vga_vsync, frame_start;
    logic [CW-1:0] vga_r, vga_g, vga_b;

    snake_pixel_compositor #(
        .NUM_LAYERS      (NL),
        .COLOR_W         (CW),
        .BLINK_FRAMES    (BF),
        .SYNC_ACTIVE_LOW (1),
        .GAMEOVER_RGB    (12'h00f)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .layer_draw  (layer_draw),
        .layer_rgb   (layer_rgb),
        .bg_rgb      (bg_rgb),
        .blink_mask  (blink_mask),
        .mode        (mode),
        .vga_hsync   (vga_hsync),
        .vga_vsync   (vga_vsync),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int   m_mode;
    int   m_cnt;
    logic m_ph;
    logic m_prev_vs;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_cnt     = 0;
        m_ph      = 1'b0;
        m_prev_vs = 1'b1;
        sb.delete();
    endtask

    // Predict the output for the inputs currently driven, then advance one clock.
    task automatic step();
        exp_t        e;
        exp_t        o;
        logic [NL-1:0] eff;
        logic [11:0] sel;
        logic [3:0]  r, g, b;
        e.fs = 1'b0;
        if (!vsync && m_prev_vs) begin
            e.fs   = 1'b1;
            m_mode = (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 0;
            if (m_mode == 2) begin
                m_cnt = 0;
                m_ph  = 1'b0;
            end else if (m_mode == 0) begin
                if (m_cnt == BF - 1) begin
                    m_cnt = 0;
                    m_ph  = ~m_ph;
                end else begin
                    m_cnt++;
                end
            end
        end
        m_prev_vs = vsync;
        eff = layer_draw & ~(m_ph ? blink_mask : 4'b0000);
        sel = bg_rgb;
        for (int i = NL - 1; i >= 0; i--)
            if (eff[i]) sel = layer_rgb[i*12 +: 12];
        if (!de)              e.rgb = 12'h000;
        else if (m_mode == 2) e.rgb = 12'h00f;
        else if (m_mode == 1) begin
            r = sel[11:8]; g = sel[7:4]; b = sel[3:0];
            r = r >> 1;    g = g >> 1;   b = b >> 1;
            e.rgb = {r, g, b};
        end else              e.rgb = sel;
        e.hs = hsync;
        e.vs = vsync;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 2) begin
            o = sb.pop_front();
            check_val("rgb", 32'({vga_r, vga_g, vga_b}), 32'(o.rgb));
            check_val("hsync", 32'(vga_hsync), 32'(o.hs));
            check_val("vsync", 32'(vga_vsync), 32'(o.vs));
            check_val("frame_start", 32'(frame_start), 32'(o.fs));
        end
    endtask

    task automatic set_pixel(input int p);
        de = 1'b1;
        if (p < 4) begin
            layer_rgb = {12'h777, 12'hc0c, 12'h3a5, 12'hf96};
            bg_rgb    = 12'h222;
        end
        case (p)
            0: begin layer_draw = 4'b0101; blink_mask = 4'b0000; end
            1: begin layer_draw = 4'b0000; blink_mask = 4'b0000; end
            2: begin layer_draw = 4'b0011; blink_mask = 4'b0001; end
            3: begin layer_draw = 4'b1000; blink_mask = 4'b1000; end
            default: begin
                layer_draw = 4'($urandom_range(0, 15));
                blink_mask = 4'($urandom_range(0, 15));
                layer_rgb  = 48'({$urandom(), $urandom()});
                bg_rgb     = 12'($urandom());
            end
        endcase
    endtask

    // One short frame: vsync pulse with blanking, then two 8-pixel lines.
    task automatic frame(input int switch_at, input logic [1:0] new_mode);
        de = 1'b0; hsync = 1'b1;
        vsync = 1'b0; step(); step();
        vsync = 1'b1; step(); step();
        for (int l = 0; l < 2; l++) begin
            hsync = 1'b1;
            for (int p = 0; p < 8; p++) begin
                if (l == 0 && p == switch_at) mode = new_mode;
                set_pixel(p);
                step();
            end
            de = 1'b0; hsync = 1'b0; step(); step();
            hsync = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        #12;
        check_val("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
        check_val("rst_hsync", 32'(vga_hsync), 32'h1);
        check_val("rst_vsync", 32'(vga_vsync), 32'h1);
        check_val("rst_frame_start", 32'(frame_start), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int f = 0; f < 6; f++) frame(-1, 2'd0);
        frame(3, 2'd1);
        frame(-1, 2'd1); frame(-1, 2'd1);
        frame(3, 2'd2);
        frame(-1, 2'd2); frame(-1, 2'd2);
        frame(3, 2'd0);
        for (int f = 0; f < 4; f++) frame(-1, 2'd0);
        frame(3, 2'd3);
        frame(-1, 2'd3); frame(-1, 2'd3);

        hsync = 1'b1; vsync = 1'b1;
        for (int p = 0; p < 3; p++) begin
            set_pixel(p);
            step();
        end
        #2 reset = 1'b1;
        #1;
        check_val("midrst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
        check_val("midrst_hsync", 32'(vga_hsync), 32'h1);
        check_val("midrst_vsync", 32'(vga_vsync), 32'h1);
        check_val("midrst_frame_start", 32'(frame_start), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        mode  = 2'd0;
        model_reset();
        for (int f = 0; f < 4; f++) frame(-1, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
